// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit seven-segment scan driver with dead-time blanking and frame-aligned double buffering
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress digits above the most significant nonzero nibble)
module seg7_scan_driver #(
    parameter int DEAD_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  refreshcounter,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic        load_ack,
    output logic        frame_start,
    output logic [7:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp_n
);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    localparam logic [7:0] DEAD_LOAD = (DEAD_CYCLES > 0) ? 8'(DEAD_CYCLES - 1) : 8'd0;

    state_t      state;
    state_t      nxt_state;

    logic [2:0]  sync1;
    logic [2:0]  idx_s;
    logic [2:0]  idx_q;
    logic [2:0]  cur_idx;
    logic [7:0]  dead_cnt;

    logic [31:0] pend_value;
    logic [7:0]  pend_dp;
    logic [7:0]  pend_en;
    logic        pend_valid;

    logic [31:0] disp_value;
    logic [7:0]  disp_dp;
    logic [7:0]  disp_en;

    logic        change;
    logic        commit;
    logic [2:0]  nxt_idx;
    logic [31:0] nxt_value;
    logic [7:0]  nxt_dp;
    logic [7:0]  nxt_en;
    logic [3:0]  nibble;
    logic        suppressed;
    logic        show;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] seg;
        case (n)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Two-flop synchronizer plus previous-index register for change detection
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1 <= 3'd0;
            idx_s <= 3'd0;
            idx_q <= 3'd0;
        end else begin
            sync1 <= refreshcounter;
            idx_s <= sync1;
            idx_q <= idx_s;
        end
    end

    assign change = (idx_s != idx_q);
    assign commit = change && (idx_s == 3'd0) && pend_valid;

    // Outputs are computed from the values the registers will hold after this edge,
    // so a commit and a zero dead time both take effect on the same edge.
    always_comb begin
        nxt_idx   = change ? idx_s : cur_idx;
        nxt_value = commit ? pend_value : disp_value;
        nxt_dp    = commit ? pend_dp : disp_dp;
        nxt_en    = commit ? pend_en : disp_en;
        nibble    = nxt_value[{nxt_idx, 2'b00} +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] msd;

    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (nxt_value[4*i +: 4] != 4'h0) begin
                msd = 3'(i);
            end
        end
        suppressed = (nxt_idx > msd);
    end
`else
    always_comb begin
        suppressed = 1'b0;
    end
`endif

    assign show = nxt_en[nxt_idx] && !suppressed;

    always_comb begin
        nxt_state = state;
        if (change) begin
            nxt_state = (DEAD_CYCLES == 0) ? DRIVE : BLANK;
        end else begin
            case (state)
                IDLE:    nxt_state = IDLE;
                BLANK:   nxt_state = (dead_cnt == 8'd0) ? DRIVE : BLANK;
                DRIVE:   nxt_state = DRIVE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pend_value <= 32'd0;
            pend_dp    <= 8'd0;
            pend_en    <= 8'd0;
            pend_valid <= 1'b0;
            disp_value <= 32'd0;
            disp_dp    <= 8'd0;
            disp_en    <= 8'd0;
        end else begin
            if (commit) begin
                disp_value <= pend_value;
                disp_dp    <= pend_dp;
                disp_en    <= pend_en;
                pend_valid <= 1'b0;
            end
            // A load on the commit edge overrides the clear: old data commits, new data stays pending
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp;
                pend_en    <= digit_en;
                pend_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            cur_idx     <= 3'd0;
            dead_cnt    <= 8'd0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            anode       <= 8'hFF;
            cathode     <= 7'h7F;
            dp_n        <= 1'b1;
        end else begin
            state       <= nxt_state;
            load_ack    <= commit;
            frame_start <= change && (idx_s == 3'd0);

            if (change) begin
                cur_idx  <= idx_s;
                dead_cnt <= DEAD_LOAD;
            end else if (state == BLANK && dead_cnt != 8'd0) begin
                dead_cnt <= dead_cnt - 8'd1;
            end

            if (nxt_state == DRIVE && show) begin
                anode   <= ~(8'b0000_0001 << nxt_idx);
                cathode <= hex_to_seg(nibble);
                dp_n    <= ~nxt_dp[nxt_idx];
            end else begin
                anode   <= 8'hFF;
                cathode <= 7'h7F;
                dp_n    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int DEAD = 16;
    localparam int HOLD = 64;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic [2:0]  refreshcounter;
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  digit_en;
    logic        load;
    logic        load_ack;
    logic        frame_start;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        dp_n;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0]  idx;
        logic        ld;
        logic [31:0] v;
        logic [7:0]  d;
        logic [7:0]  e;
        logic        fs;
        logic        ack;
        logic [7:0]  a;
        logic [6:0]  c;
        logic        dpn;
    } vec_t;

    typedef struct packed {
        logic [7:0] a;
        logic [6:0] c;
        logic       dpn;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    seg7_scan_driver #(.DEAD_CYCLES(DEAD)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .refreshcounter (refreshcounter),
        .value          (value),
        .dp             (dp),
        .digit_en       (digit_en),
        .load           (load),
        .load_ack       (load_ack),
        .frame_start    (frame_start),
        .anode          (anode),
        .cathode        (cathode),
        .dp_n           (dp_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] idx, input logic ld, input logic [31:0] v,
                                input logic [7:0] d, input logic [7:0] e, input logic fs,
                                input logic ack, input logic [7:0] a, input logic [6:0] c,
                                input logic dpn);
        vec_t r;
        r.idx = idx; r.ld = ld; r.v = v; r.d = d; r.e = e;
        r.fs = fs; r.ack = ack; r.a = a; r.c = c; r.dpn = dpn;
        return r;
    endfunction

    task automatic do_load(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e);
        value = v; dp = d; digit_en = e; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic chk_blank(input string nm);
        chk({nm, "_anode"}, 32'(anode), 32'h0FF);
        chk({nm, "_cathode"}, 32'(cathode), 32'h7F);
        chk({nm, "_dpn"}, 32'(dp_n), 32'h1);
    endtask

    // Drive one digit change and follow it through blank, dead time and lit phase
    task automatic drive_step(input vec_t t, input string nm);
        exp_t ex;
        exp_t got;
        ex.a = t.a; ex.c = t.c; ex.dpn = t.dpn;
        refreshcounter = t.idx;
        exp_q.push_back(ex);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk({nm, "_blank_anode"}, 32'(anode), 32'h0FF);
        chk({nm, "_frame_start"}, 32'(frame_start), 32'(t.fs));
        chk({nm, "_load_ack"}, 32'(load_ack), 32'(t.ack));
        for (int k = 1; k < DEAD; k++) begin
            @(negedge clock);
            chk({nm, "_dead_anode"}, 32'(anode), 32'h0FF);
            chk({nm, "_pulse_fs"}, 32'(frame_start), 32'h0);
            chk({nm, "_pulse_ack"}, 32'(load_ack), 32'h0);
        end
        @(negedge clock);
        if (exp_q.size() == 0) begin
            chk({nm, "_scoreboard_empty"}, 32'h1, 32'h0);
        end else begin
            got = exp_q.pop_front();
            chk({nm, "_lit_anode"}, 32'(anode), 32'(got.a));
            chk({nm, "_lit_cathode"}, 32'(cathode), 32'(got.c));
            chk({nm, "_lit_dpn"}, 32'(dp_n), 32'(got.dpn));
        end
        repeat (HOLD - DEAD - 4) @(negedge clock);
        chk({nm, "_steady_anode"}, 32'(anode), 32'(t.a));
    endtask

    initial begin
        reset_n = 1'b0; refreshcounter = 3'd0; value = 32'd0;
        dp = 8'd0; digit_en = 8'd0; load = 1'b0;

        // Reset held for 3 cycles while refreshcounter moves
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            refreshcounter = 3'(i + 3);
            chk_blank("reset");
            chk("reset_load_ack", 32'(load_ack), 32'h0);
            chk("reset_frame_start", 32'(frame_start), 32'h0);
        end
        refreshcounter = 3'd0;
        reset_n = 1'b1;
        @(negedge clock);
        chk_blank("post_reset");
        chk("post_reset_load_ack", 32'(load_ack), 32'h0);

        // Display buffer starts empty with all digits disabled
        tbl.push_back(mk(3'd1, 1, 32'h89ABCDEF, 8'h81, 8'hFF, 0, 0, 8'hFF, 7'h7F, 1));
        for (int i = 2; i < 8; i++)
            tbl.push_back(mk(3'(i), 0, 0, 0, 0, 0, 0, 8'hFF, 7'h7F, 1));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, 1, 1, 8'hFE, 7'b0001110, 0));
        tbl.push_back(mk(3'd1, 0, 0, 0, 0, 0, 0, 8'hFD, 7'b0000110, 1));
        tbl.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 8'hFB, 7'b0100001, 1));
        tbl.push_back(mk(3'd3, 1, 32'h11111111, 8'h00, 8'hFF, 0, 0, 8'hF7, 7'b1000110, 1));
        tbl.push_back(mk(3'd4, 0, 0, 0, 0, 0, 0, 8'hEF, 7'b0000011, 1));
        tbl.push_back(mk(3'd5, 0, 0, 0, 0, 0, 0, 8'hDF, 7'b0001000, 1));
        tbl.push_back(mk(3'd6, 0, 0, 0, 0, 0, 0, 8'hBF, 7'b0010000, 1));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 0, 0, 8'h7F, 7'b0000000, 0));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, 1, 1, 8'hFE, 7'b1111001, 1));
        tbl.push_back(mk(3'd5, 1, 32'h00000A05, 8'h04, 8'hFF, 0, 0, 8'hDF, 7'b1111001, 1));
        tbl.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 8'hFB, 7'b1111001, 1));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, 1, 1, 8'hFE, 7'b0010010, 1));
        tbl.push_back(mk(3'd1, 0, 0, 0, 0, 0, 0, 8'hFD, 7'b1000000, 1));
        tbl.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 8'hFB, 7'b0001000, 0));
        tbl.push_back(mk(3'd3, 0, 0, 0, 0, 0, 0, LZ ? 8'hFF : 8'hF7, LZ ? 7'h7F : 7'b1000000, 1));
        tbl.push_back(mk(3'd7, 1, 32'h12345678, 8'h00, 8'h0F, 0, 0,
                         LZ ? 8'hFF : 8'h7F, LZ ? 7'h7F : 7'b1000000, 1));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, 1, 1, 8'hFE, 7'b0000000, 1));
        tbl.push_back(mk(3'd5, 0, 0, 0, 0, 0, 0, 8'hFF, 7'h7F, 1));
        tbl.push_back(mk(3'd3, 0, 0, 0, 0, 0, 0, 8'hF7, 7'b0010010, 1));

        foreach (tbl[n]) begin
            if (tbl[n].ld) do_load(tbl[n].v, tbl[n].d, tbl[n].e);
            drive_step(tbl[n], $sformatf("vec%0d", n));
        end

        // Load landing on the commit edge: old pending commits, new one stays pending
        do_load(32'h22222222, 8'h00, 8'hFF);
        refreshcounter = 3'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        value = 32'h33333333; load = 1'b1;
        @(posedge clock);
        @(negedge clock);
        load = 1'b0;
        chk("simul_frame_start", 32'(frame_start), 32'h1);
        chk("simul_load_ack", 32'(load_ack), 32'h1);
        chk("simul_blank", 32'(anode), 32'h0FF);
        repeat (DEAD) @(negedge clock);
        chk("simul_anode", 32'(anode), 32'h0FE);
        chk("simul_cathode", 32'(cathode), 32'(7'b0100100));
        repeat (40) @(negedge clock);
        drive_step(mk(3'd1, 0, 0, 0, 0, 0, 0, 8'hFD, 7'b0100100, 1), "simul_idx1");
        drive_step(mk(3'd0, 0, 0, 0, 0, 1, 1, 8'hFE, 7'b0110000, 1), "simul_next");

        // Change during BLANK restarts the dead time with the new index
        refreshcounter = 3'd4;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("restart_blank0", 32'(anode), 32'h0FF);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            chk("restart_blank_a", 32'(anode), 32'h0FF);
        end
        refreshcounter = 3'd6;
        for (int k = 5; k <= 22; k++) begin
            @(negedge clock);
            chk("restart_blank_b", 32'(anode), 32'h0FF);
        end
        @(negedge clock);
        chk("restart_anode", 32'(anode), 32'h0BF);
        chk("restart_cathode", 32'(cathode), 32'(7'b0110000));
        repeat (40) @(negedge clock);

        // Reset mid-operation discards a pending load
        do_load(32'h44444444, 8'h00, 8'hFF);
        reset_n = 1'b0;
        refreshcounter = 3'd0;
        @(negedge clock);
        chk_blank("midreset");
        reset_n = 1'b1;
        @(negedge clock);
        drive_step(mk(3'd1, 0, 0, 0, 0, 0, 0, 8'hFF, 7'h7F, 1), "midreset_idx1");
        drive_step(mk(3'd0, 0, 0, 0, 0, 1, 0, 8'hFF, 7'h7F, 1), "midreset_idx0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream consumer of the 3-bit refresh counter: turns the current digit index into registered, glitch-free anode/cathode drive for the 8-digit seven-segment display. It takes the index from the slow refresh domain into the system clock domain, inserts a blanking dead-time on every digit change to stop ghosting, and double-buffers the display data so that a new value only takes effect at a frame boundary.

## Interface
Parameters:
- DEAD_CYCLES, 16: system-clock cycles with all anodes off after each digit change; legal range 0–255.

Ports (clock, reset, inputs, then outputs):
- clock  in  1  system clock; the only clock of the block.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- refreshcounter  in  3  digit index from the refresh counter; slow domain, asynchronous to clock.
- value  in  32  eight hex nibbles; digit i shows value[4i+3:4i].
- dp  in  8  decimal point per digit, 1 = lit.
- digit_en  in  8  per-digit enable, 1 = digit may light.
- load  in  1  request to capture value/dp/digit_en into the pending buffer.
- load_ack  out  1  one-cycle pulse when the pending buffer commits to the display buffer.
- frame_start  out  1  one-cycle pulse when the synchronized index changes to 0.
- anode  out  8  active-low digit select.
- cathode  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.

## Operation
- Synchronizer: two-flop chain on refreshcounter gives idx_s. idx_q holds the previous idx_s. A change is any cycle with idx_s != idx_q, with no restriction to +1 steps.
- FSM states:
  - IDLE: entered at reset; all blank.
  - BLANK: anode = 8'hFF; a dead counter runs.
  - DRIVE: the digit is lit.
- On a change, from any state: latch cur_idx = idx_s and load the dead counter with DEAD_CYCLES-1, then go to BLANK. If DEAD_CYCLES == 0, go straight to DRIVE.
- BLANK: the dead counter decrements each cycle. When it is 0, go to DRIVE. A change during BLANK restarts the dead time with the new index.
- DRIVE:
  - anode[cur_idx] = 0 only if disp_en[cur_idx] = 1 and the digit is not suppressed; otherwise anode = 8'hFF.
  - cathode = standard hex decode (0–F) of the display nibble.
  - dp_n = ~disp_dp[cur_idx].
  - A suppressed or disabled digit drives cathode = 7'h7F and dp_n = 1.
- Pending buffer:
  - load = 1 copies value/dp/digit_en into pending and sets pending_valid.
  - A further load while pending_valid is set overwrites pending; the latest request wins.
- Commit: on a change with idx_s == 0, if pending_valid is set, copy pending to the display buffer, clear pending_valid, and pulse load_ack.
- Simultaneous load and commit in one cycle: the old pending contents commit. The new data becomes pending, pending_valid stays 1, and load_ack still pulses.
- frame_start pulses on every change to index 0, whether or not a commit happens.
- Reset mid-operation: all state returns to reset values on the next edge. A pending load is discarded.

## Timing
- Reset values:
  - Outputs: anode 8'hFF, cathode 7'h7F, dp_n 1, load_ack 0, frame_start 0.
  - Internal: display/pending buffers 0, pending_valid 0, synchronizer and idx_q 0, state IDLE.
- All outputs are registered. No combinational path from any input to any output.
- Input change to blank: refreshcounter changes before edge E1. idx_s updates at E2. The change is detected in the cycle after E2, so anode = 8'hFF, frame_start and load_ack are visible after E3.
- Blank to drive: the lit anode appears DEAD_CYCLES edges after blank, at E3+DEAD_CYCLES. With DEAD_CYCLES = 0 it appears at E3.
- Committed data first appears on digit 0 of the same frame, after its dead time.
- refreshcounter must stay stable for at least DEAD_CYCLES+4 clock cycles for a digit to light.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero nibble of the display buffer are suppressed (anode off). Digit 0 is never suppressed. A buffer of all zeros shows a single "0".
- LEADING_ZERO_BLANK_EN undefined: no suppression; every enabled digit shows its nibble, zeros included.

## Test plan
- Reset: hold reset_n = 0 for 3 cycles, toggling refreshcounter -> anode 8'hFF, cathode 7'h7F, dp_n 1, load_ack 0 throughout and one cycle after release.
- Scan: load value 32'h89ABCDEF, digit_en 8'hFF, DEAD_CYCLES 16, step refreshcounter 0..7 every 64 cycles. Check after the first 0..7 pass (commit on the next 0):
  - On idx 0: anode 8'hFE and cathode 7'b0001110 ("F") at E3+16.
  - On idx 7: anode 8'h7F and cathode 7'b0000000 ("8").
  - anode is 8'hFF during each 16-cycle dead window.
- Double buffer: load 32'h11111111 while idx = 3 -> display is unchanged until the next change to 0. load_ack pulses exactly once, coincident with frame_start.
- Simultaneous events:
  - load coincides with the commit edge -> old pending shown and pending_valid still 1; the new value appears one frame later.
  - A change during BLANK restarts the dead time with the new index.
- Leading zero (macro defined): value 32'h00000A05 -> digits 7..3 anode off, digit 2 shows "A", digit 1 shows "0", digit 0 shows "5". Without the macro, all 8 digits light.
- Non-sequential index 5 -> 2 -> 0: each change blanks. The jump to 0 pulses frame_start and commits pending.
